// File: rtl/arcade_input_mapper_if.sv
// arcade_input_mapper_if: hps_io key/joystick inputs and per-player control outputs of the input mapper
interface arcade_input_mapper_if #(parameter int PLAYERS = 2);
  logic [10:0]           ps2_key;
  logic [16*PLAYERS-1:0] joy_in;
  logic [PLAYERS-1:0]    autofire_en;
  logic [6*PLAYERS-1:0]  ctrl_out;
  logic [PLAYERS-1:0]    start_out;
  logic [PLAYERS-1:0]    coin_out;
  modport master (output ps2_key, joy_in, autofire_en, input ctrl_out, start_out, coin_out);
  modport slave (input ps2_key, joy_in, autofire_en, output ctrl_out, start_out, coin_out);
endinterface

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: ps2 key + joystick merge into per-player controls with SOCD cancel, autofire and coin pulses
module arcade_input_mapper #(
  parameter int PLAYERS      = 2,
  parameter int COIN_PULSE   = 2400000,
  parameter int AUTOFIRE_DIV = 1200000,
  parameter bit SOCD_NEUTRAL = 1'b1
) (
  input logic clk_sys,
  input logic reset,
  arcade_input_mapper_if.slave io
);
  localparam int CW = $clog2(COIN_PULSE + 1);
  localparam int AW = AUTOFIRE_DIV > 1 ? $clog2(AUTOFIRE_DIV) : 1;
  // entry = {valid, ext, code}; per player functions R,L,D,U,fireA,fireB,start,coin with up to two keys each
  localparam logic [0:3][0:7][0:1][9:0] KEY_MAP = '{
    '{'{10'h374, 10'h000}, '{10'h36B, 10'h000}, '{10'h372, 10'h000}, '{10'h375, 10'h000},
      '{10'h214, 10'h000}, '{10'h211, 10'h000}, '{10'h205, 10'h216}, '{10'h276, 10'h22E}},
    '{'{10'h234, 10'h000}, '{10'h223, 10'h000}, '{10'h22B, 10'h000}, '{10'h22D, 10'h000},
      '{10'h21C, 10'h000}, '{10'h21B, 10'h000}, '{10'h206, 10'h21E}, '{10'h236, 10'h000}},
    '{'{10'h24B, 10'h000}, '{10'h23B, 10'h000}, '{10'h242, 10'h000}, '{10'h243, 10'h000},
      '{10'h244, 10'h000}, '{10'h24D, 10'h000}, '{10'h204, 10'h226}, '{10'h23D, 10'h000}},
    '{'{10'h274, 10'h000}, '{10'h26B, 10'h000}, '{10'h272, 10'h000}, '{10'h275, 10'h000},
      '{10'h270, 10'h000}, '{10'h271, 10'h000}, '{10'h20C, 10'h225}, '{10'h23E, 10'h000}}
  };

  logic                         tog_q, tog_d;
  logic [16*PLAYERS-1:0]        key_q, key_d;
  logic [6*PLAYERS-1:0]         ctrl_q, ctrl_d;
  logic [PLAYERS-1:0]           start_q, start_d;
  logic [PLAYERS-1:0]           coin_raw_q, coin_raw_d;
  logic [PLAYERS-1:0][CW-1:0]   coin_cnt_q, coin_cnt_d;
  logic [AW-1:0]                af_cnt_q, af_cnt_d;
  logic                         af_ph_q, af_ph_d;
  logic                         key_evt, af_wrap, socd_h, socd_v;
  logic [7:0]                   raw;
  logic [PLAYERS-1:0]           coin_on;

  always_comb begin
    tog_d = io.ps2_key[10];
    key_evt = io.ps2_key[10] != tog_q;
    af_wrap = af_cnt_q == AW'(AUTOFIRE_DIV - 1);
    af_cnt_d = af_wrap ? '0 : af_cnt_q + 1'b1;
    af_ph_d = af_ph_q ^ af_wrap;
    key_d = key_q;
    ctrl_d = '0;
    start_d = '0;
    coin_raw_d = '0;
    coin_cnt_d = coin_cnt_q;
    coin_on = '0;
    raw = '0;
    socd_h = 1'b0;
    socd_v = 1'b0;
    for (int p = 0; p < PLAYERS; p++) begin
      for (int f = 0; f < 8; f++) begin
        for (int a = 0; a < 2; a++)
          if (key_evt && KEY_MAP[p][f][a][9] && KEY_MAP[p][f][a][8:0] == io.ps2_key[8:0])
            key_d[16*p+2*f+a] = io.ps2_key[9];
        raw[f] = key_q[16*p+2*f] | key_q[16*p+2*f+1] | io.joy_in[16*p+f];
      end
      socd_h = SOCD_NEUTRAL && raw[0] && raw[1];
      socd_v = SOCD_NEUTRAL && raw[2] && raw[3];
      ctrl_d[6*p +: 6] = {raw[5], raw[4] & (af_ph_q | ~io.autofire_en[p]),
                          raw[3:2] & {2{~socd_v}}, raw[1:0] & {2{~socd_h}}};
      start_d[p] = raw[6];
      coin_raw_d[p] = raw[7];
      // a new edge only loads an idle slot, so held or repeated presses never stretch the pulse
      coin_cnt_d[p] = (raw[7] && !coin_raw_q[p] && coin_cnt_q[p] == '0) ? CW'(COIN_PULSE) :
                      (coin_cnt_q[p] != '0) ? coin_cnt_q[p] - 1'b1 : coin_cnt_q[p];
      coin_on[p] = coin_cnt_q[p] != '0;
    end
  end

  always_ff @(posedge clk_sys) begin
    tog_q <= tog_d;
    if (reset) begin
      key_q      <= '0;
      ctrl_q     <= '0;
      start_q    <= '0;
      coin_raw_q <= '0;
      coin_cnt_q <= '0;
      af_cnt_q   <= '0;
      af_ph_q    <= 1'b1;
    end else begin
      key_q      <= key_d;
      ctrl_q     <= ctrl_d;
      start_q    <= start_d;
      coin_raw_q <= coin_raw_d;
      coin_cnt_q <= coin_cnt_d;
      af_cnt_q   <= af_cnt_d;
      af_ph_q    <= af_ph_d;
    end
  end

  assign io.ctrl_out  = ctrl_q;
  assign io.start_out = start_q;
  assign io.coin_out  = coin_on;
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: directed checks of a 4-player and a 2-player mapper sharing one ps2 key stream
module tb_arcade_input_mapper;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;

  arcade_input_mapper_if #(.PLAYERS(4)) if4();
  arcade_input_mapper_if #(.PLAYERS(2)) if2();

  arcade_input_mapper #(.PLAYERS(4), .COIN_PULSE(10), .AUTOFIRE_DIV(4), .SOCD_NEUTRAL(1'b1))
    dut4 (.clk_sys(clk), .reset(rst), .io(if4.slave));
  arcade_input_mapper #(.PLAYERS(2), .COIN_PULSE(10), .AUTOFIRE_DIV(4), .SOCD_NEUTRAL(1'b1))
    dut2 (.clk_sys(clk), .reset(rst), .io(if2.slave));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_key(input bit pr, input bit ext, input logic [7:0] code);
    if4.ps2_key = {~if4.ps2_key[10], pr, ext, code};
    if2.ps2_key = if4.ps2_key;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    checks++;
    if (if4.ctrl_out !== 24'h0 || if4.start_out !== 4'h0 || if4.coin_out !== 4'h0) begin
      failures++;
      $display("FAIL reset4 ctrl=%h start=%h coin=%h want 0", if4.ctrl_out, if4.start_out, if4.coin_out);
    end
    checks++;
    if (if2.ctrl_out !== 12'h0 || if2.start_out !== 2'h0 || if2.coin_out !== 2'h0) begin
      failures++;
      $display("FAIL reset2 ctrl=%h start=%h coin=%h want 0", if2.ctrl_out, if2.start_out, if2.coin_out);
    end
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_key_p1;
    send_key(1, 1, 8'h75);
    step(1);
    checks++;
    if (if4.ctrl_out !== 24'h0) begin
      failures++;
      $display("FAIL key_latency ctrl=%h want 000000", if4.ctrl_out);
    end
    step(1);
    checks++;
    if (if4.ctrl_out !== 24'h000008) begin
      failures++;
      $display("FAIL key_p1_up ctrl=%h want 000008", if4.ctrl_out);
    end
    checks++;
    if (if2.ctrl_out !== 12'h008) begin
      failures++;
      $display("FAIL key_p1_up2 ctrl=%h want 008", if2.ctrl_out);
    end
    send_key(0, 1, 8'h75);
    step(2);
    checks++;
    if (if4.ctrl_out !== 24'h0) begin
      failures++;
      $display("FAIL key_p1_release ctrl=%h want 000000", if4.ctrl_out);
    end
  endtask

  task automatic test_p4_numpad;
    send_key(1, 0, 8'h75);
    step(2);
    checks++;
    if (if4.ctrl_out !== 24'h200000) begin
      failures++;
      $display("FAIL p4_up ctrl=%h want 200000", if4.ctrl_out);
    end
    checks++;
    if (if2.ctrl_out !== 12'h0) begin
      failures++;
      $display("FAIL p4_ignored ctrl=%h want 000", if2.ctrl_out);
    end
    send_key(0, 0, 8'h75);
    step(2);
  endtask

  task automatic test_socd;
    if4.joy_in = 64'h3;
    step(1);
    checks++;
    if (if4.ctrl_out[5:0] !== 6'h00) begin
      failures++;
      $display("FAIL socd_rl got=%h want 00", if4.ctrl_out[5:0]);
    end
    if4.joy_in = 64'h1;
    step(1);
    checks++;
    if (if4.ctrl_out[5:0] !== 6'h01) begin
      failures++;
      $display("FAIL socd_r got=%h want 01", if4.ctrl_out[5:0]);
    end
    if4.joy_in = 64'h1C;
    step(1);
    checks++;
    if (if4.ctrl_out[5:0] !== 6'h10) begin
      failures++;
      $display("FAIL socd_ud got=%h want 10", if4.ctrl_out[5:0]);
    end
    if4.joy_in = 64'h2;
    send_key(1, 1, 8'h74);
    step(1);
    checks++;
    if (if4.ctrl_out[5:0] !== 6'h02) begin
      failures++;
      $display("FAIL socd_mix1 got=%h want 02", if4.ctrl_out[5:0]);
    end
    step(1);
    checks++;
    if (if4.ctrl_out[5:0] !== 6'h00) begin
      failures++;
      $display("FAIL socd_mix2 got=%h want 00", if4.ctrl_out[5:0]);
    end
    send_key(0, 1, 8'h74);
    if4.joy_in = 64'h0;
    step(2);
  endtask

  task automatic test_start;
    send_key(1, 0, 8'h05);
    step(2);
    checks++;
    if (if4.start_out !== 4'b0001) begin
      failures++;
      $display("FAIL start_f1 got=%b want 0001", if4.start_out);
    end
    send_key(1, 0, 8'h16);
    step(1);
    send_key(0, 0, 8'h05);
    step(2);
    checks++;
    if (if4.start_out !== 4'b0001) begin
      failures++;
      $display("FAIL start_or got=%b want 0001", if4.start_out);
    end
    send_key(0, 0, 8'h16);
    step(2);
    checks++;
    if (if4.start_out !== 4'b0000) begin
      failures++;
      $display("FAIL start_rel got=%b want 0000", if4.start_out);
    end
    send_key(1, 0, 8'h1E);
    step(2);
    checks++;
    if (if2.start_out !== 2'b10) begin
      failures++;
      $display("FAIL start_p2 got=%b want 10", if2.start_out);
    end
    send_key(0, 0, 8'h1E);
    step(2);
  endtask

  task automatic test_coin;
    int highs = 0;
    int rises = 0;
    int other = 0;
    logic prev = 1'b0;
    for (int c = 0; c < 25; c++) begin
      if (c == 0 || c == 5) send_key(1, 0, 8'h76);
      if (c == 3 || c == 7) send_key(0, 0, 8'h76);
      step(1);
      if (if4.coin_out[0]) highs++;
      if (if4.coin_out[0] && !prev) rises++;
      prev = if4.coin_out[0];
    end
    checks++;
    if (highs != 10) begin
      failures++;
      $display("FAIL coin_len got=%0d want 10", highs);
    end
    checks++;
    if (rises != 1) begin
      failures++;
      $display("FAIL coin_retrigger rises=%0d want 1", rises);
    end
    highs = 0;
    if4.joy_in[23] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 15) if4.joy_in[23] = 1'b0;
      step(1);
      if (if4.coin_out[1]) highs++;
      if (if4.coin_out[0]) other++;
    end
    checks++;
    if (highs != 10 || other != 0) begin
      failures++;
      $display("FAIL coin_slot1 len=%0d slot0=%0d want 10 0", highs, other);
    end
  endtask

  task automatic test_autofire;
    logic v;
    logic ok = 1'b1;
    bit found = 0;
    if4.autofire_en = 4'b0001;
    if4.joy_in = 64'h10;
    step(1);
    v = if4.ctrl_out[4];
    for (int i = 0; i < 10 && !found; i++) begin
      step(1);
      if (if4.ctrl_out[4] !== v) found = 1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL autofire_toggle got=stuck %b want toggling", v);
    end
    v = if4.ctrl_out[4];
    for (int i = 1; i < 8; i++) begin
      step(1);
      checks++;
      if (if4.ctrl_out[4] !== ((i < 4) ? v : ~v)) begin
        failures++;
        $display("FAIL autofire_phase%0d got=%b want %b", i, if4.ctrl_out[4], (i < 4) ? v : ~v);
      end
    end
    if4.joy_in = 64'h20;
    for (int i = 0; i < 9; i++) begin
      step(1);
      if (i > 0 && if4.ctrl_out[5] !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL autofire_fireb got=gaps want steady 1");
    end
    if4.autofire_en = 4'b0000;
    if4.joy_in = 64'h10;
    for (int i = 0; i < 9; i++) begin
      step(1);
      if (if4.ctrl_out[4] !== 1'b1) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL autofire_off got=gaps want steady 1");
    end
    if4.joy_in = 64'h0;
    step(2);
  endtask

  task automatic test_back_to_back;
    if4.joy_in[20] = 1'b1;
    send_key(1, 0, 8'h1B);
    step(1);
    checks++;
    if (if4.ctrl_out[11:10] !== 2'b01) begin
      failures++;
      $display("FAIL same_cycle1 got=%b want 01", if4.ctrl_out[11:10]);
    end
    step(1);
    checks++;
    if (if4.ctrl_out[11:10] !== 2'b11) begin
      failures++;
      $display("FAIL same_cycle2 got=%b want 11", if4.ctrl_out[11:10]);
    end
    if4.joy_in = 64'h0;
    send_key(0, 0, 8'h1B);
    step(2);
  endtask

  task automatic test_reset_mid;
    send_key(1, 0, 8'h76);
    step(1);
    send_key(1, 1, 8'h75);
    step(3);
    checks++;
    if (if4.coin_out[0] !== 1'b1 || if4.ctrl_out[3] !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset coin=%b up=%b want 1 1", if4.coin_out[0], if4.ctrl_out[3]);
    end
    rst = 1'b1;
    step(1);
    checks++;
    if (if4.ctrl_out !== 24'h0 || if4.coin_out !== 4'h0 || if2.coin_out !== 2'h0) begin
      failures++;
      $display("FAIL reset_mid ctrl=%h coin=%h coin2=%h want 0", if4.ctrl_out, if4.coin_out, if2.coin_out);
    end
    send_key(1, 0, 8'h76);
    step(1);
    rst = 1'b0;
    step(4);
    checks++;
    if (if4.ctrl_out !== 24'h0 || if4.coin_out !== 4'h0 || if4.start_out !== 4'h0) begin
      failures++;
      $display("FAIL reset_release ctrl=%h coin=%h start=%h want 0", if4.ctrl_out, if4.coin_out, if4.start_out);
    end
  endtask

  initial begin
    rst = 1'b1;
    if4.ps2_key = '0;
    if2.ps2_key = '0;
    if4.joy_in = '0;
    if2.joy_in = '0;
    if4.autofire_en = '0;
    if2.autofire_en = '0;
    test_reset;
    test_key_p1;
    test_p4_numpad;
    test_socd;
    test_start;
    test_coin;
    test_autofire;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
